fsl_byte_unpacker: RTL and testbench

- Upstream neighbour of the FSL-to-serial bridge.
- Accepts 32-bit words from a MicroBlaze FSL master and re-emits them as single-byte FSL transactions in bits [24:31], the only lane the bridge transmits.
- Lets software push four characters per FSL write instead of one.
- Partial words (1–3 bytes) are sent as control-tagged words carrying a byte count.

---
 rtl/fsl_pkg.sv | 23 ++
 rtl/fsl_byte_unpacker_if.sv | 17 +
 rtl/fsl_byte_unpacker.sv | 109 ++++++++++
 tb/tb_fsl_byte_unpacker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsl_pkg.sv
// Shared definitions for the FSL byte unpacker and the FSL-to-serial bridge.
// Holds the state encoding, the word and byte geometry, and the position of
// the byte-count field used by partial words.
package fsl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } fsl_state_t;

  localparam int FSL_WIDTH      = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  // Byte count of a partial word sits in the two least significant bits.
  localparam int CNT_MSB     = 30;
  localparam int CNT_LSB     = 31;
  localparam int PARTIAL_MAX = 3;

  typedef logic [0:FSL_WIDTH-1] fsl_word_t;
  typedef logic [2:0]           byte_cnt_t;

endpackage

// File: rtl/fsl_byte_unpacker_if.sv
// One FSL link. The writing side uses the master modport and the reading
// side uses the slave modport. The unpacker is a slave on its upstream
// link and a master on its downstream link.
interface fsl_byte_unpacker_if;
  import fsl_pkg::*;

  fsl_word_t data;
  logic      control;
  logic      exists;
  logic      read;
  logic      full;
  logic      write;

  modport master (output data, output control, output write, input full);
  modport slave  (input data, input control, input exists, output read);

endinterface

// File: rtl/fsl_byte_unpacker.sv
// Splits 32-bit FSL words into single-byte FSL writes on lane [24:31].
// A word tagged with control=1 is a partial word: its count field [30:31]
// gives 1..3 payload bytes taken from [0:7], [8:15], [16:23]. A count of 0
// is consumed and dropped.
// MSB_FIRST=0 reverses the order of the used byte lanes.
// Build option: define FSL_UNPACK_LAST_MARK_EN to flag the last byte of each
// word on FSL_M_CONTROL. Otherwise FSL_M_CONTROL stays 0.
//
// state | meaning
// IDLE  | no latched bytes; read the next word when one exists
// EMIT  | write head byte on every non-full cycle until none remain
module fsl_byte_unpacker
  import fsl_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       FSL_S_CLK,
  output logic                       FSL_M_CLK,
  fsl_byte_unpacker_if.slave         s_fsl,
  fsl_byte_unpacker_if.master        m_fsl,
  output logic                       busy
);

  fsl_state_t state_q, state_d;
  fsl_word_t  word_q, word_d;
  byte_cnt_t  rem_q, rem_d;
  logic [1:0] part_cnt;
  logic       read;
  logic       write;

  assign part_cnt = s_fsl.data[CNT_MSB:CNT_LSB];

  // Put the bytes in emission order so that EMIT only ever shifts left.
  function automatic fsl_word_t order_lanes(input fsl_word_t d, input logic partial,
                                            input logic [1:0] cnt);
    fsl_word_t r;
    r = d;
    if (!MSB_FIRST) begin
      if (!partial) r = {d[24:31], d[16:23], d[8:15], d[0:7]};
      else if (cnt == 2'd2) r = {d[8:15], d[0:7], d[16:31]};
      else if (cnt == 2'd3) r = {d[16:23], d[8:15], d[0:7], d[24:31]};
    end
    return r;
  endfunction

  // State, shift register and remaining-byte counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic plus the read and write strobes.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rem_d   = rem_q;
    read    = 1'b0;
    write   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_fsl.exists) begin
          read = 1'b1;
          if (!s_fsl.control) begin
            word_d  = order_lanes(s_fsl.data, 1'b0, part_cnt);
            rem_d   = byte_cnt_t'(BYTES_PER_WORD);
            state_d = EMIT;
          end else if (part_cnt != 2'd0) begin
            word_d  = order_lanes(s_fsl.data, 1'b1, part_cnt);
            rem_d   = {1'b0, part_cnt};
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (!m_fsl.full) begin
          write  = 1'b1;
          word_d = {word_q[BYTE_W:FSL_WIDTH-1], {BYTE_W{1'b0}}};
          rem_d  = rem_q - 3'd1;
          if (rem_q == 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign FSL_S_CLK   = clock;
  assign FSL_M_CLK   = clock;
  assign busy        = (state_q == EMIT);
  assign s_fsl.read  = read;
  assign m_fsl.write = write;
  // Lane [24:31] is held at 0 outside EMIT so leftover partial-word bits never show.
  assign m_fsl.data  = {24'h000000, busy ? word_q[0:BYTE_W-1] : 8'h00};

`ifdef FSL_UNPACK_LAST_MARK_EN
  assign m_fsl.control = write & (rem_q == 3'd1);
`else
  assign m_fsl.control = 1'b0;
`endif

endmodule

// File: tb/tb_fsl_byte_unpacker.sv
// Bench for fsl_byte_unpacker. Two instances (MSB_FIRST=1 and 0) receive
// identical stimulus. A queue-based reference model expands every consumed
// word into its expected byte sequence, and each observed write is checked
// against the front of that queue.
module tb_fsl_byte_unpacker;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fsl_byte_unpacker_if s1 ();
  fsl_byte_unpacker_if m1 ();
  fsl_byte_unpacker_if s0 ();
  fsl_byte_unpacker_if m0 ();
  logic s_clk1, m_clk1, busy1, s_clk0, m_clk0, busy0;

  fsl_byte_unpacker #(.MSB_FIRST(1'b1)) dut1 (
    .clock(clock), .reset(reset), .FSL_S_CLK(s_clk1), .FSL_M_CLK(m_clk1),
    .s_fsl(s1), .m_fsl(m1), .busy(busy1));
  fsl_byte_unpacker #(.MSB_FIRST(1'b0)) dut0 (
    .clock(clock), .reset(reset), .FSL_S_CLK(s_clk0), .FSL_M_CLK(m_clk0),
    .s_fsl(s0), .m_fsl(m0), .busy(busy0));

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp1[$], exp0[$];   // {last, byte} expected writes
  logic [8:0] obs1[$], obs0[$];   // {control, byte} observed writes

  typedef struct {
    logic [31:0] w;
    logic        ctl;
    int          n;
    logic [31:0] e1;
    logic [31:0] e0;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a word expands to its payload bytes in big-endian order,
  // reversed for MSB_FIRST=0. The last byte carries the last-byte flag.
  task automatic model_push(input logic [31:0] w, input logic ctl);
    logic [7:0] b[$];
    int n;
    n = ctl ? int'(w[1:0]) : 4;
    for (int i = 0; i < n; i++) b.push_back(w[31-8*i -: 8]);
    for (int i = 0; i < n; i++) begin
      exp1.push_back({(i == n - 1), b[i]});
      exp0.push_back({(i == n - 1), b[n-1-i]});
    end
  endtask

  task automatic chk_write(input int idx, input logic [31:0] d, input logic c);
    logic [8:0] e;
    n_tests++;
    if ((idx == 1 && exp1.size() == 0) || (idx == 0 && exp0.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_write dut%0d: got byte 0x%0h expected no write", idx, d[7:0]);
      return;
    end
    if (idx == 1) begin e = exp1.pop_front(); obs1.push_back({c, d[7:0]}); end
    else          begin e = exp0.pop_front(); obs0.push_back({c, d[7:0]}); end
    check(idx == 1 ? "byte_msb1" : "byte_msb0", {24'h0, d[7:0]}, {24'h0, e[7:0]});
    check(idx == 1 ? "hi_zero_msb1" : "hi_zero_msb0", {8'h0, d[31:8]}, 32'h0);
`ifdef FSL_UNPACK_LAST_MARK_EN
    check(idx == 1 ? "last_mark_msb1" : "last_mark_msb0", {31'h0, c}, {31'h0, e[8]});
`else
    check(idx == 1 ? "ctl_zero_msb1" : "ctl_zero_msb0", {31'h0, c}, 32'h0);
`endif
  endtask

  // Monitor: sample away from the active edge; reset must force everything low.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_write", {30'h0, m1.write, m0.write}, 32'h0);
      check("rst_busy", {30'h0, busy1, busy0}, 32'h0);
      check("rst_data", m1.data | m0.data, 32'h0);
      check("rst_ctl", {30'h0, m1.control, m0.control}, 32'h0);
    end else begin
      if (s1.read !== s0.read) check("read_lockstep", {31'h0, s0.read}, {31'h0, s1.read});
      if (s1.read) model_push(s1.data, s1.control);
      if (m1.write) chk_write(1, m1.data, m1.control);
      if (m0.write) chk_write(0, m0.data, m0.control);
    end
  end

  task automatic drive_s(input logic ex, input logic [31:0] w, input logic ctl);
    s1.exists = ex; s1.data = w; s1.control = ctl;
    s0.exists = ex; s0.data = w; s0.control = ctl;
  endtask

  task automatic set_full(input logic f);
    m1.full = f; m0.full = f;
  endtask

  task automatic send_word(input logic [31:0] w, input logic ctl);
    logic got;
    @(posedge clock); #1;
    drive_s(1'b1, w, ctl);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      got = s1.read;
    end
    check("read_seen", {31'h0, got}, 32'h1);
    @(posedge clock); #1;
    drive_s(1'b0, w, ctl);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clock);
      done = !busy1 && !busy0;
    end
    check("drain_bound", {31'h0, done}, 32'h1);
  endtask

  task automatic clear_obs();
    obs1.delete(); obs0.delete();
  endtask

  task automatic check_seq(input string name, input int n, input logic [63:0] e1,
                           input logic [63:0] e0);
    check({name, "_cnt1"}, obs1.size(), n);
    check({name, "_cnt0"}, obs0.size(), n);
    if (obs1.size() == n && obs0.size() == n)
      for (int i = 0; i < n; i++) begin
        check({name, "_b1"}, {24'h0, obs1[i][7:0]}, {24'h0, e1[63-8*i -: 8]});
        check({name, "_b0"}, {24'h0, obs0[i][7:0]}, {24'h0, e0[63-8*i -: 8]});
      end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nmark;
    int r1, r2;
    logic took;
    logic [31:0] w;

    tbl[0] = '{32'h41424344, 1'b0, 4, 32'h41424344, 32'h44434241};
    tbl[1] = '{32'h61620002, 1'b1, 2, 32'h61620000, 32'h62610000};
    tbl[2] = '{32'h00000000, 1'b1, 0, 32'h00000000, 32'h00000000};
    tbl[3] = '{32'h7A000001, 1'b1, 1, 32'h7A000000, 32'h7A000000};
    tbl[4] = '{32'h31323303, 1'b1, 3, 32'h31323300, 32'h33323100};
    tbl[5] = '{32'hFF00FF00, 1'b0, 4, 32'hFF00FF00, 32'h00FF00FF};

    reset = 1'b0;
    drive_s(1'b0, 32'h0, 1'b0);
    set_full(1'b0);
    s1.full = 1'b0; s1.write = 1'b0; s0.full = 1'b0; s0.write = 1'b0;
    m1.exists = 1'b0; m1.read = 1'b0; m0.exists = 1'b0; m0.read = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", {30'h0, busy1, busy0}, 32'h0);
    check("reset_data", m1.data, 32'h0);
    @(posedge clock); #1;
    check("clk_fwd", {28'h0, s_clk1, m_clk1, s_clk0, m_clk0}, 32'hF);
    reset = 1'b1;

    // Table-driven single words, downstream never full.
    foreach (tbl[t]) begin
      clear_obs();
      send_word(tbl[t].w, tbl[t].ctl);
      @(negedge clock);
      check("first_write_latency", {31'h0, m1.write}, {31'h0, (tbl[t].n > 0)});
      if (tbl[t].n == 0) check("count0_busy", {31'h0, busy1}, 32'h0);
      drain();
      check_seq("tbl", tbl[t].n, {tbl[t].e1, 32'h0}, {tbl[t].e0, 32'h0});
    end

    // FULL held for 10 cycles after the first byte.
    clear_obs();
    send_word(32'h01020304, 1'b0);
    @(negedge clock);
    check("full_first_write", {31'h0, m1.write}, 32'h1);
    @(posedge clock); #1;
    set_full(1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("full_no_write", {30'h0, m1.write, m0.write}, 32'h0);
      check("full_hold_msb1", {24'h0, m1.data[24:31]}, 32'h02);
      check("full_hold_msb0", {24'h0, m0.data[24:31]}, 32'h03);
    end
    @(posedge clock); #1;
    set_full(1'b0);
    drain();
    check_seq("full", 4, 64'h01020304_00000000, 64'h04030201_00000000);

    // Two queued words with EXISTS held high.
    clear_obs();
    r1 = -1; r2 = -1;
    @(posedge clock); #1;
    drive_s(1'b1, 32'hA0A1A2A3, 1'b0);
    for (int k = 0; k < 30 && r2 < 0; k++) begin
      @(negedge clock);
      if (s1.read) begin
        if (r1 < 0) r1 = k;
        else r2 = k;
      end
      @(posedge clock); #1;
      if (r2 >= 0) drive_s(1'b0, 32'h0, 1'b0);
      else if (r1 >= 0) drive_s(1'b1, 32'hB0B1B2B3, 1'b0);
    end
    check("b2b_read_gap", r2 - r1, 5);
    drain();
    check_seq("b2b", 8, 64'hA0A1A2A3_B0B1B2B3, 64'hA3A2A1A0_B3B2B1B0);
    nmark = 0;
    foreach (obs1[i]) if (obs1[i][8]) nmark++;
`ifdef FSL_UNPACK_LAST_MARK_EN
    check("b2b_marks", nmark, 2);
    if (obs1.size() == 8) check("b2b_mark_pos", {24'h0, obs1[3][8], obs1[7][8], 6'h0}, 32'hC0);
`else
    check("b2b_marks", nmark, 0);
`endif

    // Reset in the middle of EMIT, after the second byte.
    clear_obs();
    send_word(32'h11223344, 1'b0);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("pre_rst_byte", {24'h0, m1.data[24:31]}, 32'h22);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("rst_now_write", {30'h0, m1.write, m0.write}, 32'h0);
    check("rst_now_busy", {30'h0, busy1, busy0}, 32'h0);
    check("rst_now_data", m1.data | m0.data, 32'h0);
    exp1.delete(); exp0.delete();
    clear_obs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_no_write", obs1.size() + obs0.size(), 0);
    send_word(32'h55667788, 1'b0);
    drain();
    check_seq("post_rst", 4, 64'h55667788_00000000, 64'h88776655_00000000);

    // Randomized traffic: toggling FULL first, then random FULL and gaps.
    took = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clock);
      took = s1.read;
      @(posedge clock); #1;
      if (took) drive_s(1'b0, 32'h0, 1'b0);
      if (!s1.exists && ($urandom % 3 == 0)) begin
        w = $urandom;
        drive_s(1'b1, w, ($urandom % 3 == 0));
      end
      set_full((cyc < 200) ? cyc[0] : ($urandom % 4 == 0));
    end
    drive_s(1'b0, 32'h0, 1'b0);
    set_full(1'b0);
    drain();
    check("rand_left1", exp1.size(), 0);
    check("rand_left0", exp0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
